// File: rtl/padd_scheduler.sv
// Issue scheduler for the shared pipelined point adder: arbitrates the pair FIFOs,
// tracks adder credits and detects end of period. Optional PADD_SCHED_TMP_PRIO_EN gives tmp strict priority.
module padd_scheduler #(
  parameter int POINT_WIDTH  = 96,
  parameter int INDEX_WIDTH  = 4,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     write_over,
  input  logic                     empty_u1,
  input  logic                     empty_u2,
  input  logic                     empty_tmp,
  input  logic [2*POINT_WIDTH-1:0] pout_u1,
  input  logic [2*POINT_WIDTH-1:0] pout_u2,
  input  logic [2*POINT_WIDTH-1:0] pout_tmp,
  input  logic [INDEX_WIDTH-1:0]   index_u1,
  input  logic [INDEX_WIDTH-1:0]   index_u2,
  input  logic [INDEX_WIDTH-1:0]   index_tmp,
  output logic                     re_u1,
  output logic                     re_u2,
  output logic                     re_tmp,
  output logic                     padd_valid,
  output logic [POINT_WIDTH-1:0]   padd_a,
  output logic [POINT_WIDTH-1:0]   padd_b,
  output logic [INDEX_WIDTH-1:0]   padd_index,
  input  logic                     padd_done,
  output logic                     busy,
  output logic                     stall,
  output logic                     done
);

  localparam int              CW      = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_INFLIGHT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] SEL_U1  = 2'd0;
  localparam logic [1:0] SEL_U2  = 2'd1;
  localparam logic [1:0] SEL_TMP = 2'd2;

  logic [1:0]            state;
  logic [1:0]            rr_ptr;
  logic [1:0]            rr_ptr_nxt;
  logic [1:0]            sel_q;
  logic [CW-1:0]         inflight;
  logic                  wo_seen;
  logic                  quiet_q;
  logic                  re_any_q;
  logic [2:0]            elig;
  logic [2:0]            gnt;
  logic [1:0]            gnt_sel;
  logic                  grant_any;
  logic                  retire;
  logic                  drain;
  logic [2*POINT_WIDTH-1:0] pair;

  assign stall     = (inflight == MAX_CNT);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign retire    = padd_done && (inflight != '0);
  assign grant_any = |gnt;
  assign drain     = wo_seen && empty_u1 && empty_u2 && empty_tmp &&
                     !re_any_q && (inflight == '0) && !padd_done;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    elig = {~empty_tmp, ~empty_u2, ~empty_u1} & {3{(state == S_RUN) && !stall}};
    gnt  = 3'b000;
`ifdef PADD_SCHED_TMP_PRIO_EN
    if (elig[2])
      gnt = 3'b100;
    else if (rr_ptr == SEL_U2)
      gnt = elig[1] ? 3'b010 : (elig[0] ? 3'b001 : 3'b000);
    else
      gnt = elig[0] ? 3'b001 : (elig[1] ? 3'b010 : 3'b000);
`else
    case (rr_ptr)
      SEL_U2:  gnt = elig[1] ? 3'b010 : elig[2] ? 3'b100 : elig[0] ? 3'b001 : 3'b000;
      SEL_TMP: gnt = elig[2] ? 3'b100 : elig[0] ? 3'b001 : elig[1] ? 3'b010 : 3'b000;
      default: gnt = elig[0] ? 3'b001 : elig[1] ? 3'b010 : elig[2] ? 3'b100 : 3'b000;
    endcase
`endif
  end

  assign re_u1  = gnt[0];
  assign re_u2  = gnt[1];
  assign re_tmp = gnt[2];

  always_comb begin
    gnt_sel    = SEL_U1;
    rr_ptr_nxt = rr_ptr;
    if (gnt[1]) gnt_sel = SEL_U2;
    if (gnt[2]) gnt_sel = SEL_TMP;
`ifdef PADD_SCHED_TMP_PRIO_EN
    // tmp grants bypass the rotation, so they leave the u1/u2 pointer alone
    if (gnt[0]) rr_ptr_nxt = SEL_U2;
    if (gnt[1]) rr_ptr_nxt = SEL_U1;
`else
    if (gnt[0]) rr_ptr_nxt = SEL_U2;
    if (gnt[1]) rr_ptr_nxt = SEL_TMP;
    if (gnt[2]) rr_ptr_nxt = SEL_U1;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rr_ptr   <= SEL_U1;
      inflight <= '0;
      wo_seen  <= 1'b0;
      quiet_q  <= 1'b0;
      re_any_q <= 1'b0;
    end else begin
      rr_ptr   <= rr_ptr_nxt;
      re_any_q <= grant_any;
      case ({grant_any, retire})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      case (state)
        S_IDLE: begin
          quiet_q <= 1'b0;
          if (start) state <= S_RUN;
        end
        S_RUN: begin
          if (write_over) wo_seen <= 1'b1;
          if (drain) begin
            quiet_q <= 1'b1;
            if (quiet_q) begin
              state   <= S_DONE;
              quiet_q <= 1'b0;
            end
          end else begin
            quiet_q <= 1'b0;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          wo_seen <= 1'b0;
          quiet_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      padd_valid <= 1'b0;
      sel_q      <= SEL_U1;
    end else begin
      padd_valid <= grant_any;
      sel_q      <= gnt_sel;
    end
  end

  // The FIFO read register is the operand pipeline stage; outputs are zero when not valid.
  always_comb begin
    pair       = '0;
    padd_index = '0;
    if (padd_valid) begin
      case (sel_q)
        SEL_U2:  begin pair = pout_u2;  padd_index = index_u2;  end
        SEL_TMP: begin pair = pout_tmp; padd_index = index_tmp; end
        default: begin pair = pout_u1;  padd_index = index_u1;  end
      endcase
    end
  end

  assign padd_a = pair[2*POINT_WIDTH-1:POINT_WIDTH];
  assign padd_b = pair[POINT_WIDTH-1:0];

endmodule

// File: tb/tb_padd_scheduler.sv
// Randomised self-checking bench for padd_scheduler: FIFO/adder environment plus a
// transaction-level reference model of arbitration, credits and period control.
module tb_padd_scheduler;
  localparam int PW  = 96;
  localparam int IW  = 4;
  localparam int MI  = 8;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, write_over = 1'b0, padd_done = 1'b0;
  logic empty_u1 = 1'b1, empty_u2 = 1'b1, empty_tmp = 1'b1;
  logic [2*PW-1:0] pout_u1 = '0, pout_u2 = '0, pout_tmp = '0;
  logic [IW-1:0] index_u1 = '0, index_u2 = '0, index_tmp = '0;
  logic re_u1, re_u2, re_tmp, padd_valid, busy, stall, done;
  logic [PW-1:0] padd_a, padd_b;
  logic [IW-1:0] padd_index;

  always #5 clk = ~clk;

  padd_scheduler #(.POINT_WIDTH(PW), .INDEX_WIDTH(IW), .MAX_INFLIGHT(MI)) dut (
    .clk(clk), .rst(rst), .start(start), .write_over(write_over),
    .empty_u1(empty_u1), .empty_u2(empty_u2), .empty_tmp(empty_tmp),
    .pout_u1(pout_u1), .pout_u2(pout_u2), .pout_tmp(pout_tmp),
    .index_u1(index_u1), .index_u2(index_u2), .index_tmp(index_tmp),
    .re_u1(re_u1), .re_u2(re_u2), .re_tmp(re_tmp),
    .padd_valid(padd_valid), .padd_a(padd_a), .padd_b(padd_b), .padd_index(padd_index),
    .padd_done(padd_done), .busy(busy), .stall(stall), .done(done)
  );

  typedef struct { logic [2*PW-1:0] data; logic [IW-1:0] idx; int gen; } item_t;
  typedef struct { item_t it; int ready; } flight_t;
  typedef enum { M_IDLE, M_RUN, M_DONE } mst_t;

  item_t   fq [3][$];
  flight_t pipe[$];

  // reference model state
  mst_t  m_st;
  int    m_ptr, m_cred, m_last;
  bit    m_wo, m_quiet;
  item_t m_out;

  // values sampled before the active edge
  int s_g;
  bit s_pdone, s_start, s_wo, s_allempty;

  int n_checks = 0, n_errors = 0, cyc = 0, n_re = 0;
  int budget = -1, push_prob = 0;
  bit feedback_en = 0, rand_hold = 0, done_seen = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_empties();
    empty_u1  = (fq[0].size() == 0);
    empty_u2  = (fq[1].size() == 0);
    empty_tmp = (fq[2].size() == 0);
  endtask

  task automatic push(input int f, input logic [IW-1:0] idx);
    item_t it;
    it.data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    it.idx  = idx;
    it.gen  = 0;
    fq[f].push_back(it);
    set_empties();
  endtask

  function automatic void model_reset();
    m_st = M_IDLE; m_ptr = 0; m_cred = 0; m_last = -1; m_wo = 0; m_quiet = 0;
  endfunction

  function automatic int model_grant();
    bit el[3];
    int c;
    for (int i = 0; i < 3; i++) el[i] = (m_st == M_RUN) && (fq[i].size() > 0) && (m_cred < MI);
`ifdef PADD_SCHED_TMP_PRIO_EN
    if (el[2]) return 2;
    for (int k = 0; k < 2; k++) begin
      c = (m_ptr + k) % 2;
      if (el[c]) return c;
    end
`else
    for (int k = 0; k < 3; k++) begin
      c = (m_ptr + k) % 3;
      if (el[c]) return c;
    end
`endif
    return -1;
  endfunction

  function automatic void model_step();
    bit drain;
    drain = m_wo && s_allempty && (m_last < 0) && (m_cred == 0) && !s_pdone;
    m_cred = m_cred + ((s_g >= 0) ? 1 : 0) - ((s_pdone && m_cred > 0) ? 1 : 0);
    case (m_st)
      M_IDLE: if (s_start) m_st = M_RUN;
      M_RUN: begin
        if (s_wo) m_wo = 1;
        if (!drain) m_quiet = 0;
        else if (m_quiet) begin m_st = M_DONE; m_quiet = 0; end
        else m_quiet = 1;
      end
      default: begin m_st = M_IDLE; m_wo = 0; end
    endcase
`ifdef PADD_SCHED_TMP_PRIO_EN
    if (s_g == 0 || s_g == 1) m_ptr = (s_g + 1) % 2;
`else
    if (s_g >= 0) m_ptr = (s_g + 1) % 3;
`endif
    m_last = s_g;
  endfunction

  // One clock: compare at the falling edge, then advance environment and model after the rising edge.
  task automatic cycle();
    int g;
    logic [2*PW-1:0] exp_pair;
    flight_t fl;
    @(negedge clk);
    if (rst) model_reset();
    g = model_grant();
    exp_pair = (m_last >= 0) ? m_out.data : '0;
    check("re_u1", re_u1, g == 0);
    check("re_u2", re_u2, g == 1);
    check("re_tmp", re_tmp, g == 2);
    check("stall", stall, m_cred == MI);
    check("busy", busy, m_st != M_IDLE);
    check("done", done, m_st == M_DONE);
    check("padd_valid", padd_valid, m_last >= 0);
    check("padd_index", padd_index, (m_last >= 0) ? m_out.idx : '0);
    check("padd_a", padd_a, exp_pair[2*PW-1:PW]);
    check("padd_b", padd_b, exp_pair[PW-1:0]);
    if (done) done_seen = 1;
    if (re_u1 | re_u2 | re_tmp) n_re++;
    if (m_last >= 0) begin
      fl.it = m_out; fl.ready = cyc + LAT;
      pipe.push_back(fl);
    end
    s_g = g; s_pdone = padd_done; s_start = start; s_wo = write_over;
    s_allempty = empty_u1 && empty_u2 && empty_tmp;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) model_reset();
    else begin
      if (s_g >= 0) begin
        m_out = fq[s_g].pop_front();
        case (s_g)
          0: begin pout_u1  = m_out.data; index_u1  = m_out.idx; end
          1: begin pout_u2  = m_out.data; index_u2  = m_out.idx; end
          default: begin pout_tmp = m_out.data; index_tmp = m_out.idx; end
        endcase
      end
      model_step();
    end
    padd_done = 1'b0;
    if (pipe.size() > 0 && pipe[0].ready <= cyc && budget != 0 &&
        !(rand_hold && $urandom_range(3) == 0)) begin
      fl = pipe.pop_front();
      padd_done = 1'b1;
      if (budget > 0) budget--;
      if (feedback_en && fl.it.gen == 0 && (!rand_hold || $urandom_range(1) == 1)) begin
        fl.it.gen  = 1;
        fl.it.data = ~fl.it.data;
        fq[2].push_back(fl.it);
      end
    end
    if (push_prob > 0 && $urandom_range(99) < push_prob) push($urandom_range(2), IW'($urandom));
    set_empties();
  endtask

  task automatic run_period_end(input int limit);
    write_over = 1'b1;
    done_seen  = 0;
    for (int i = 0; i < limit && !done_seen; i++) cycle();
    write_over = 1'b0;
    check("done_reached", done_seen, 1'b1);
    cycle();
    cycle();
  endtask

  task automatic begin_period();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) cycle();
    rst = 1'b0;

    // u1 holds three pairs, indices 1..3
    push(0, 4'd1); push(0, 4'd2); push(0, 4'd3);
    begin_period();
    repeat (6) cycle();
    run_period_end(60);

    // all three FIFOs busy
    for (int i = 0; i < 4; i++) begin push(0, IW'(i)); push(1, IW'(i + 4)); push(2, IW'(i + 8)); end
    begin_period();
    repeat (16) cycle();
    run_period_end(80);

    // credit exhaustion with the adder holding results
    budget = 0;
    for (int i = 0; i < 10; i++) push(0, IW'(i));
    begin_period();
    n_re = 0;
    repeat (14) cycle();
    check("grants_at_stall", n_re, 8);
    check("stall_held", stall, 1'b1);
    n_re = 0;
    budget = 1;
    repeat (4) cycle();
    check("grants_after_one_done", n_re, 1);
    budget = -1;
    run_period_end(80);

    // results fed back into tmp must be drained before done
    feedback_en = 1;
    push(0, 4'd5); push(1, 4'd6);
    begin_period();
    run_period_end(100);
    feedback_en = 0;

    // grant and retire in the same cycle at seven credits
    budget = 0;
    for (int i = 0; i < 7; i++) push(0, IW'(i));
    begin_period();
    repeat (10) cycle();
    budget = 1;
    cycle();
    push(1, 4'd9);
    cycle();
    cycle();
    check("stall_after_grant_and_done", stall, 1'b0);
    budget = -1;
    run_period_end(80);

    // reset in the middle of a run
    budget = 0;
    for (int i = 0; i < 5; i++) push(0, IW'(i));
    begin_period();
    repeat (7) cycle();
    rst = 1'b1;
    padd_done = 1'b0;
    pipe.delete();
    for (int i = 0; i < 3; i++) fq[i].delete();
    set_empties();
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_valid", padd_valid, 1'b0);
    repeat (2) cycle();
    rst = 1'b0;
    budget = -1;
    push(1, 4'd3); push(0, 4'd4);
    begin_period();
    run_period_end(60);

    // random traffic periods
    for (int p = 0; p < 4; p++) begin
      rand_hold = 1; feedback_en = 1; push_prob = 45;
      begin_period();
      repeat (40) cycle();
      push_prob = 0;
      run_period_end(400);
      rand_hold = 0; feedback_en = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/padd_scheduler.md
# padd_scheduler

Issue scheduler for the shared pipelined point adder in the bucket-accumulation stage of main compute. It arbitrates among the three pair FIFOs (pair FIFO 1, pair FIFO 2, result-tmp FIFO), pops one point pair per cycle into the adder, and tracks in-flight additions against a credit limit. It also detects end of period and pulses `done`.

## Interface
- POINT_WIDTH, 96: width of one projective point (3×32).
- INDEX_WIDTH, 4: bucket index width.
- MAX_INFLIGHT, 8: adder credit limit; must be ≤ FIFO_DEPTH (15) of the result-tmp FIFO.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a compute period (sampled in IDLE only).
- write_over  in  1  upstream finished writing this period (sticky once seen in RUN).
- empty_u1, empty_u2, empty_tmp  in  1 each  FIFO empty flags.
- pout_u1, pout_u2, pout_tmp  in  2*POINT_WIDTH each  FIFO read data {X,Y}; valid the cycle after `re`.
- index_u1, index_u2, index_tmp  in  INDEX_WIDTH each  bucket index accompanying pout.
- re_u1, re_u2, re_tmp  out  1 each  FIFO read enables, one-hot or zero.
- padd_valid  out  1  operand pair valid to adder.
- padd_a, padd_b  out  POINT_WIDTH each  operands (X and Y halves of popped pair).
- padd_index  out  INDEX_WIDTH  bucket index sent with operands.
- padd_done  in  1  adder retires one result this cycle.
- busy  out  1  FSM not IDLE.
- stall  out  1  inflight == MAX_INFLIGHT.
- done  out  1  one-cycle end-of-period pulse.

## Operation
- FSM: IDLE → RUN on `start`; RUN → DONE when drain condition holds 2 consecutive cycles; DONE → IDLE unconditionally (`done`=1 in DONE only).
- Drain condition: write_over latched, all three empties high, no `re` in previous cycle, inflight == 0, padd_done low.
- Eligible requester: its empty low and stall low; issue only in RUN.
- Arbitration: round-robin over u1 → u2 → tmp; pointer advances to grantee+1 after each grant; no grant leaves pointer unchanged.
- At most one `re` per cycle; popped data registered to padd_a/padd_b/padd_index with padd_valid the next cycle.
- inflight counter (clog2(MAX_INFLIGHT+1) bits): +1 on grant, −1 on padd_done, both same cycle → unchanged. Grant counts at `re` time, so credits cover the one-cycle read latency.
- padd_done with inflight==0 is ignored (counter saturates at 0); inflight never exceeds MAX_INFLIGHT.
- `start` in RUN/DONE ignored; write_over outside RUN ignored; write_over latch cleared on entering IDLE.
- Reset mid-operation: all state cleared immediately, in-flight results discarded by design contract.

## Timing
- Reset values: re_*=0, padd_valid=0, padd_a/b=0, padd_index=0, busy=0, stall=0, done=0, FSM=IDLE, RR pointer=u1, inflight=0.
- re at cycle t → padd_valid at t+1 with that FIFO's data/index.
- Sustained throughput one pair/cycle while credits and data available.
- stall is combinational from inflight register; re outputs combinational from registered state and empties.
- done asserted at earliest 2 cycles after the last quiet cycle begins; busy falls the cycle after done.

## Configuration
- PADD_SCHED_TMP_PRIO_EN defined: result-tmp FIFO has strict priority whenever nonempty; round-robin applies only between u1 and u2. This drains partial sums first and bounds tmp occupancy.
- Undefined: plain 3-way round-robin as above.

## Test plan
- Reset then start, u1 holds 3 pairs (idx 1,2,3), others empty → re_u1 cycles 1–3, padd_valid cycles 2–4 with indices 1,2,3; inflight reaches 3.
- All three FIFOs nonempty continuously → grants u1,u2,tmp,u1,… one per cycle; with macro defined → tmp granted every cycle until empty.
- No padd_done, 10 pairs queued → exactly 8 grants, stall=1, re held 0; one padd_done → exactly one further grant.
- write_over, FIFOs empty, inflight 2 returned by padd_done into tmp → no done until tmp re-drained and retired; then done one-cycle pulse, busy falls next cycle.
- Simultaneous grant and padd_done at inflight=8−1 → inflight stays 7, stall stays 0.
- rst asserted mid-RUN with inflight=5 → next cycle all outputs at reset values, FSM IDLE, start restarts cleanly.
